keypad_scanner: RTL and testbench

Matrix scanner for the 4x4 board keypad. Drives one column low at a time, samples the four row inputs through a two-flop synchronizer and assembles a 16-bit raw key vector once per full scan. The vector `tempkey` feeds the keyboard debouncer directly.

---
 rtl/keypad_scanner.sv | 120 ++++++++++++
 tb/tb_keypad_scanner.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// keypad_scanner
//   4x4 matrix keypad scanner. Walks an active-low column strobe, samples the
//   rows through a two-flop synchronizer and publishes a 16-bit raw key frame.
//   Optional macro: KEYPAD_GHOST_REJECT_EN (drop frames with 3+ keys set).
// Revision: 1.0
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV = 50_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] tempkey,
  output logic        frame_done,
  output logic        ghost
);

  localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("keypad_scanner: SCAN_DIV must be >= 4");
  end

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] div_cnt;
  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [11:0]      shadow;
  logic [3:0]       pressed;
  logic [15:0]      candidate;
  logic             sample;
  logic             publish;
  logic             reject;

  assign pressed   = ~row_sync;
  assign sample    = (div_cnt == CNT_LAST);
  assign publish   = sample && (state == COL3);
  // COL3 rows go straight into the frame; they never need to be shadowed.
  assign candidate = {pressed, shadow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta   <= 4'hF;
      row_sync   <= 4'hF;
      state      <= COL0;
      col        <= 4'b1110;
      div_cnt    <= '0;
      shadow     <= '0;
      tempkey    <= '0;
      frame_done <= 1'b0;
    end else begin
      row_meta   <= row;
      row_sync   <= row_meta;
      frame_done <= 1'b0;
      if (sample) begin
        div_cnt <= '0;
        case (state)
          COL0: begin
            shadow[3:0] <= pressed;
            state       <= COL1;
            col         <= 4'b1101;
          end
          COL1: begin
            shadow[7:4] <= pressed;
            state       <= COL2;
            col         <= 4'b1011;
          end
          COL2: begin
            shadow[11:8] <= pressed;
            state        <= COL3;
            col          <= 4'b0111;
          end
          COL3: begin
            state <= COL0;
            col   <= 4'b1110;
          end
          default: begin
            state <= COL0;
            col   <= 4'b1110;
          end
        endcase
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (publish && !reject) begin
        tempkey    <= candidate;
        frame_done <= 1'b1;
      end
    end
  end

`ifdef KEYPAD_GHOST_REJECT_EN
  // Three or more closed keys on a diode-less matrix may include phantom keys.
  assign reject = ($countones(candidate) > 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghost <= 1'b0;
    end else begin
      ghost <= publish && reject;
    end
  end
`else
  assign reject = 1'b0;
  assign ghost  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// tb_keypad_scanner
//   Self-checking bench: keypad matrix model, frame-level reference model,
//   vector table, directed corner sequences and randomized key patterns.
// Revision: 1.0
// ============================================================================
module tb_keypad_scanner;

  localparam int SD    = 8;
  localparam int FRAME = 4 * SD;
`ifdef KEYPAD_GHOST_REJECT_EN
  localparam bit REJECT = 1'b1;
`else
  localparam bit REJECT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] tempkey;
  logic        frame_done;
  logic        ghost;

  logic [15:0] keys   = '0;
  logic [3:0]  glitch = '0;

  int checks = 0;
  int errors = 0;

  keypad_scanner #(.SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row        (row),
    .col        (col),
    .tempkey    (tempkey),
    .frame_done (frame_done),
    .ghost      (ghost)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a held key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col[c]) row = row & ~keys[4*c +: 4];
    row = row & ~glitch;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edge count since reset decides column and publish points;
  // the row pins seen two edges earlier are what a sample edge captures.
  int unsigned m_edge;
  logic [3:0]  m_d1, m_d2;
  logic [15:0] m_groups;
  logic [15:0] m_tempkey;
  logic        m_fd, m_ghost;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edge    = 0;
      m_d1      = 4'hF;
      m_d2      = 4'hF;
      m_groups  = '0;
      m_tempkey = '0;
      m_fd      = 1'b0;
      m_ghost   = 1'b0;
    end else begin
      int unsigned c;
      m_edge++;
      m_fd    = 1'b0;
      m_ghost = 1'b0;
      if (m_edge % SD == 0) begin
        c = (m_edge / SD - 1) % 4;
        m_groups[4*c +: 4] = ~m_d2;
        if (c == 3) begin
          if (REJECT && $countones(m_groups) >= 3) m_ghost = 1'b1;
          else begin
            m_tempkey = m_groups;
            m_fd      = 1'b1;
          end
        end
      end
      m_d2 = m_d1;
      m_d1 = row;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic [3:0] one;
      one = 4'b0001;
      chk("model_col", {12'h0, col}, {12'h0, ~(one << ((m_edge / SD) % 4))});
      chk("model_tempkey", tempkey, m_tempkey);
      chk("model_frame_done", {15'h0, frame_done}, {15'h0, m_fd});
      chk("model_ghost", {15'h0, ghost}, {15'h0, m_ghost});
    end
  end

  // Reset with the given keys held; returns at the negedge just after release.
  task automatic restart(input logic [15:0] k);
    rst_n  = 1'b0;
    keys   = k;
    glitch = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic [15:0] keys;
    logic [15:0] exp_key;
    logic        exp_fd;
    logic        exp_ghost;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [3:0] one;
    one = 4'b0001;

    vecs[0] = '{"no_keys",    16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{"single_c2r1",16'h0200, 16'h0200, 1'b1, 1'b0};
    vecs[2] = '{"two_keys",   16'h8001, 16'h8001, 1'b1, 1'b0};
    vecs[3] = '{"single_c1r2",16'h0040, 16'h0040, 1'b1, 1'b0};
    vecs[4] = '{"three_keys", 16'h0013, REJECT ? 16'h0000 : 16'h0013, !REJECT, REJECT};
    vecs[5] = '{"four_keys",  16'h1111, REJECT ? 16'h0000 : 16'h1111, !REJECT, REJECT};

    // Reset state and column walk
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_col", {12'h0, col}, 16'h000E);
    chk("rst_tempkey", tempkey, 16'h0000);
    chk("rst_frame_done", {15'h0, frame_done}, 16'h0);
    chk("rst_ghost", {15'h0, ghost}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      chk("walk_col", {12'h0, col}, {12'h0, ~(one << ((k / SD) % 4))});
      chk("walk_frame_done", {15'h0, frame_done}, {15'h0, (k == 32)});
    end

    // Vector table: keys held from reset, first publish at edge 32
    for (int i = 0; i < 6; i++) begin
      restart(vecs[i].keys);
      repeat (FRAME - 1) @(negedge clk);
      chk({vecs[i].name, "_early_fd"}, {15'h0, frame_done}, 16'h0);
      @(negedge clk);
      chk({vecs[i].name, "_tempkey"}, tempkey, vecs[i].exp_key);
      chk({vecs[i].name, "_fd"}, {15'h0, frame_done}, {15'h0, vecs[i].exp_fd});
      chk({vecs[i].name, "_ghost"}, {15'h0, ghost}, {15'h0, vecs[i].exp_ghost});
    end

    // Single key repeats every frame, clears after release
    restart(16'h0200);
    repeat (2 * FRAME) @(negedge clk);
    chk("repeat_tempkey", tempkey, 16'h0200);
    chk("repeat_fd", {15'h0, frame_done}, 16'h1);
    keys = 16'h0000;
    repeat (FRAME) @(negedge clk);
    chk("release_tempkey", tempkey, 16'h0000);
    chk("release_fd", {15'h0, frame_done}, 16'h1);

    // Three keys after a one-key frame
    restart(16'h0001);
    repeat (FRAME) @(negedge clk);
    chk("pre3_tempkey", tempkey, 16'h0001);
    keys = 16'h0013;
    repeat (FRAME) @(negedge clk);
    chk("three_tempkey", tempkey, REJECT ? 16'h0001 : 16'h0013);
    chk("three_fd", {15'h0, frame_done}, {15'h0, !REJECT});
    chk("three_ghost", {15'h0, ghost}, {15'h0, REJECT});

    // Asynchronous reset during COL2 of the second frame
    restart(16'h0040);
    repeat (FRAME + 20) @(negedge clk);
    chk("mid_pre_tempkey", tempkey, 16'h0040);
    chk("mid_pre_col", {12'h0, col}, 16'h000B);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_col", {12'h0, col}, 16'h000E);
    chk("mid_async_tempkey", tempkey, 16'h0000);
    chk("mid_async_fd", {15'h0, frame_done}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME - 1) @(negedge clk);
    chk("mid_edge31_tempkey", tempkey, 16'h0000);
    @(negedge clk);
    chk("mid_edge32_tempkey", tempkey, 16'h0040);
    chk("mid_edge32_fd", {15'h0, frame_done}, 16'h1);

    // Two-cycle glitch on row[0] in the middle of COL1
    restart(16'h0000);
    repeat (10) @(negedge clk);
    glitch = 4'b0001;
    repeat (2) @(negedge clk);
    glitch = 4'b0000;
    repeat (FRAME - 12) @(negedge clk);
    chk("glitch_tempkey", tempkey, 16'h0000);
    chk("glitch_fd", {15'h0, frame_done}, 16'h1);

    // Randomized key patterns and glitches, checked by the model every cycle
    restart(16'h0000);
    for (int it = 0; it < 60; it++) begin
      logic [15:0] k;
      int n;
      k = '0;
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) k[$urandom_range(0, 15)] = 1'b1;
      keys = k;
      repeat ($urandom_range(5, 90)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        glitch = 4'($urandom_range(1, 15));
        repeat ($urandom_range(1, 2)) @(negedge clk);
        glitch = '0;
      end
    end
    repeat (2 * FRAME) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
